// File: rtl/set_region_counter_pkg.sv
// Shared definitions for the lattice-point set-region counter: set-mode
// encodings, FSM state encoding and width helpers.
package set_pkg;

    // Set-mode encodings carried on the mode input.
    localparam logic [2:0] MODE_C0   = 3'd0;  // inside circle 0
    localparam logic [2:0] MODE_AND  = 3'd1;  // inside circle 0 and circle 1
    localparam logic [2:0] MODE_XOR  = 3'd2;  // inside exactly one of circle 0 / circle 1
    localparam logic [2:0] MODE_EQK  = 3'd3;  // membership count equals k
    localparam logic [2:0] MODE_GEK  = 3'd4;  // membership count at least k
    localparam logic [2:0] MODE_ANY  = 3'd5;  // inside at least one circle
    localparam logic [2:0] MODE_ALL  = 3'd6;  // inside every circle
    localparam logic [2:0] MODE_RSVD = 3'd7;  // reserved, never hits

    // Job sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    // Width needed to hold a membership count in 0..num_circ.
    function automatic int kw_for(input int num_circ);
        return clog2(num_circ + 1);
    endfunction

endpackage

// File: rtl/set_point_judge.sv
// One evaluation lane: decides whether a single grid point belongs to the
// selected set region, given the latched circle configuration.
module set_point_judge
    import set_pkg::*;
#(
    parameter int COORD_W  = 4,
    parameter int NUM_CIRC = 3,
    parameter int KW       = 2
) (
    input  logic [COORD_W-1:0]            px,
    input  logic [COORD_W-1:0]            py,
    input  logic [NUM_CIRC*2*COORD_W-1:0] central,
    input  logic [NUM_CIRC*COORD_W-1:0]   radius,
    input  logic [2:0]                    mode,
    input  logic [KW-1:0]                 k,
    output logic                          hit
);

    // inside_d[c] is set when the point lies in circle c.
    logic [NUM_CIRC-1:0] inside_d;
    logic [KW-1:0]       m_d;

    for (genvar gi = 0; gi < NUM_CIRC; gi++) begin : g_circ
        // Circle 0 occupies the most significant slice of each bus.
        localparam int CB = (NUM_CIRC - 1 - gi) * 2 * COORD_W;
        localparam int RB = (NUM_CIRC - 1 - gi) * COORD_W;

        logic [COORD_W-1:0]   cx, cy, r, dx, dy;
        logic [2*COORD_W-1:0] dx_sq, dy_sq, r_sq;
        logic [2*COORD_W:0]   dist_sq;

        assign cx = central[CB+COORD_W +: COORD_W];
        assign cy = central[CB +: COORD_W];
        assign r  = radius[RB +: COORD_W];

        // Absolute differences keep the squares unsigned and exact.
        assign dx = (px >= cx) ? (px - cx) : (cx - px);
        assign dy = (py >= cy) ? (py - cy) : (cy - py);

        assign dx_sq   = {{COORD_W{1'b0}}, dx} * {{COORD_W{1'b0}}, dx};
        assign dy_sq   = {{COORD_W{1'b0}}, dy} * {{COORD_W{1'b0}}, dy};
        assign r_sq    = {{COORD_W{1'b0}}, r}  * {{COORD_W{1'b0}}, r};
        assign dist_sq = {1'b0, dx_sq} + {1'b0, dy_sq};

        assign inside_d[gi] = (dist_sq <= {1'b0, r_sq});
    end

    // Count how many circles contain the point.
    always_comb begin
        m_d = '0;
        for (int c = 0; c < NUM_CIRC; c++) begin
            m_d = m_d + {{(KW-1){1'b0}}, inside_d[c]};
        end
    end

    // Apply the selected set-mode to the membership pattern.
    always_comb begin
        hit = 1'b0;
        case (mode)
            MODE_C0:  hit = inside_d[0];
            MODE_AND: hit = inside_d[0] & inside_d[1];
            MODE_XOR: hit = inside_d[0] ^ inside_d[1];
            MODE_EQK: hit = (m_d == k);
            MODE_GEK: hit = (m_d >= k);
            MODE_ANY: hit = (m_d != '0);
            MODE_ALL: hit = (m_d == KW'(NUM_CIRC));
            default:  hit = 1'b0;
        endcase
    end

endmodule

// File: rtl/set_region_counter.sv
// Scans a GRID_W x GRID_W lattice LANES points per cycle and counts the
// points that satisfy the selected set-mode over NUM_CIRC circles. The result
// is presented with a valid/ready handshake; a new job may be accepted on the
// same edge the previous result is consumed.
module set_region_counter
    import set_pkg::*;
#(
    parameter int GRID_W   = 8,
    parameter int COORD_W  = 4,
    parameter int NUM_CIRC = 3,
    parameter int LANES    = 1,
    parameter int CNT_W    = 8,
    parameter int KW       = kw_for(NUM_CIRC)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [NUM_CIRC*2*COORD_W-1:0] central,
    input  logic [NUM_CIRC*COORD_W-1:0]   radius,
    input  logic [2:0]                    mode,
    input  logic [KW-1:0]                 k,
    input  logic                          out_ready,
    output logic                          busy,
    output logic                          valid,
    output logic [CNT_W-1:0]              candidate,
    output logic                          mode_err
);

    // Number of scan steps per job and the index width that covers them.
    localparam int S     = (GRID_W * GRID_W) / LANES;
    localparam int IDX_W = (S > 1) ? clog2(S) : 1;

    state_t                        state_q;
    logic [IDX_W-1:0]              idx_q;
    logic [LANES-1:0]              hit_q;
    logic [CNT_W-1:0]              cand_q;
    logic                          valid_q;
    logic                          busy_q;
    logic                          err_q;
    logic [NUM_CIRC*2*COORD_W-1:0] central_q;
    logic [NUM_CIRC*COORD_W-1:0]   radius_q;
    logic [2:0]                    mode_q;
    logic [KW-1:0]                 k_q;

    logic [LANES-1:0]              hit_d;
    logic [CNT_W-1:0]              pop_d;
    logic                          accept_d;

    // A job starts from IDLE, or from DONE when the result is consumed on the same edge.
    assign accept_d = en && ((state_q == ST_IDLE) ||
                             ((state_q == ST_DONE) && out_ready));

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [31:0]        p;
        logic [COORD_W-1:0] px, py;

        // Lane gi at index i covers point i*LANES+gi, mapped row-major onto 1..GRID_W.
        assign p  = 32'(idx_q) * LANES + gi;
        assign px = COORD_W'(p / GRID_W + 1);
        assign py = COORD_W'(p % GRID_W + 1);

        set_point_judge #(
            .COORD_W  (COORD_W),
            .NUM_CIRC (NUM_CIRC),
            .KW       (KW)
        ) u_judge (
            .px      (px),
            .py      (py),
            .central (central_q),
            .radius  (radius_q),
            .mode    (mode_q),
            .k       (k_q),
            .hit     (hit_d[gi])
        );
    end

    // Population count of the registered lane hits from the previous step.
    always_comb begin
        pop_d = '0;
        for (int j = 0; j < LANES; j++) begin
            pop_d = pop_d + {{(CNT_W-1){1'b0}}, hit_q[j]};
        end
    end

    // Job FSM with the index counter, hit pipeline register and accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            hit_q     <= '0;
            cand_q    <= '0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            central_q <= '0;
            radius_q  <= '0;
            mode_q    <= MODE_C0;
            k_q       <= '0;
        end else if (accept_d) begin
            central_q <= central;
            radius_q  <= radius;
            mode_q    <= mode;
            k_q       <= k;
            idx_q     <= '0;
            hit_q     <= '0;
            cand_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= ST_SCAN;
        end else begin
            case (state_q)
                ST_SCAN: begin
                    // The first step adds zero because hit_q was cleared on accept.
                    hit_q  <= hit_d;
                    cand_q <= cand_q + pop_d;
                    if (idx_q == IDX_W'(S - 1)) begin
                        state_q <= ST_DRAIN;
                    end else begin
                        idx_q <= idx_q + IDX_W'(1);
                    end
                end
                ST_DRAIN: begin
                    // Fold in the hits of the last scan step and publish the result.
                    cand_q  <= cand_q + pop_d;
                    hit_q   <= '0;
                    valid_q <= 1'b1;
                    busy_q  <= 1'b0;
                    err_q   <= (mode_q == MODE_RSVD);
                    state_q <= ST_DONE;
                end
                ST_DONE: begin
                    // Consumed without a follow-on job: fall back to IDLE, keep the count.
                    if (out_ready) begin
                        valid_q <= 1'b0;
                        err_q   <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign candidate = cand_q;
    assign mode_err  = err_q;

endmodule

// File: tb/tb_set_region_counter.sv
// Scoreboard bench for set_region_counter: directed jobs push their
// hand-computed results into a queue and a negedge monitor pops and compares
// each result as it is handed over. A second instance covers LANES=4.
module tb_set_region_counter;

    localparam int GW  = 8;
    localparam int CW  = 4;
    localparam int NC  = 3;
    localparam int CNT = 8;
    localparam int KW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              en;
    logic              en4;
    logic [NC*2*CW-1:0] central;
    logic [NC*CW-1:0]  radius;
    logic [2:0]        mode;
    logic [KW-1:0]     k;
    logic              out_ready;
    logic              out_ready4;
    logic              busy, valid, mode_err;
    logic [CNT-1:0]    candidate;
    logic              busy4, valid4, mode_err4;
    logic [CNT-1:0]    candidate4;

    typedef struct {
        int          id;
        logic [7:0]  cand;
        logic        err;
    } exp_t;

    exp_t q[$];
    exp_t q4[$];

    int n_cmp = 0;
    int n_bad = 0;
    int job_id = 0;

    always #5 clk = ~clk;

    set_region_counter #(
        .GRID_W(GW), .COORD_W(CW), .NUM_CIRC(NC), .LANES(1), .CNT_W(CNT)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
        .mode(mode), .k(k), .out_ready(out_ready), .busy(busy), .valid(valid),
        .candidate(candidate), .mode_err(mode_err)
    );

    set_region_counter #(
        .GRID_W(GW), .COORD_W(CW), .NUM_CIRC(NC), .LANES(4), .CNT_W(CNT)
    ) dut4 (
        .clk(clk), .rst(rst), .en(en4), .central(central), .radius(radius),
        .mode(mode), .k(k), .out_ready(out_ready4), .busy(busy4), .valid(valid4),
        .candidate(candidate4), .mode_err(mode_err4)
    );

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor for the LANES=1 instance: compares on each result handover.
    always @(negedge clk) begin
        if (!rst && valid && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("job %0d: candidate=%0d (exp %0d) mode_err=%0b (exp %0b)",
                         e.id, candidate, e.cand, mode_err, e.err);
                check("candidate", int'(candidate), int'(e.cand));
                check("mode_err", int'(mode_err), int'(e.err));
            end
        end
    end

    // Monitor for the LANES=4 instance.
    always @(negedge clk) begin
        if (!rst && valid4 && out_ready4) begin
            if (q4.size() == 0) begin
                check("unexpected_result_l4", 1, 0);
            end else begin
                exp_t e;
                e = q4.pop_front();
                $display("lanes4 job %0d: candidate=%0d (exp %0d) mode_err=%0b (exp %0b)",
                         e.id, candidate4, e.cand, mode_err4, e.err);
                check("candidate_l4", int'(candidate4), int'(e.cand));
                check("mode_err_l4", int'(mode_err4), int'(e.err));
            end
        end
    end

    task automatic set_circ(input int c, input int x, input int y, input int r);
        central[(NC-1-c)*2*CW +: 2*CW] = {x[CW-1:0], y[CW-1:0]};
        radius[(NC-1-c)*CW +: CW]      = r[CW-1:0];
    endtask

    // Centre (0,0) with radius 0 never contains a grid point.
    task automatic circ_off(input int c);
        set_circ(c, 0, 0, 0);
    endtask

    // Pulses en for one edge (the accept edge E0) and optionally records the expectation.
    task automatic start_job(input int md, input int kk, input int ecand,
                             input int eerr, input bit push);
        exp_t e;
        mode = md[2:0];
        k    = kk[KW-1:0];
        if (push) begin
            e.id   = job_id;
            e.cand = ecand[7:0];
            e.err  = eerr[0];
            q.push_back(e);
        end
        job_id++;
        en = 1'b1;
        @(posedge clk);
        #1;
        en = 1'b0;
    endtask

    // Counts edges after the accept edge until valid is seen.
    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!valid) check("valid_timeout", 0, 1);
    endtask

    int n;
    int seen;

    initial begin
        rst        = 1'b1;
        en         = 1'b0;
        en4        = 1'b0;
        out_ready  = 1'b1;
        out_ready4 = 1'b1;
        central    = '0;
        radius     = '0;
        mode       = 3'd0;
        k          = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", int'(busy), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_candidate", int'(candidate), 0);
        check("reset_mode_err", int'(mode_err), 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single circle at (4,4) r=2: 13 points, latency 65 edges.
        set_circ(0, 4, 4, 2); circ_off(1); circ_off(2);
        start_job(0, 0, 13, 0, 1'b1);
        check("busy_in_scan", int'(busy), 1);
        wait_valid(n);
        check("latency_l1", n, 65);

        // Two coincident circles.
        set_circ(1, 4, 4, 2);
        start_job(1, 0, 13, 0, 1'b1); wait_valid(n);
        start_job(2, 0, 0, 0, 1'b1);  wait_valid(n);

        // Covers whole grid; then a single-point radius-0 circle at the corner.
        set_circ(0, 8, 8, 15); circ_off(1);
        start_job(0, 0, 64, 0, 1'b1); wait_valid(n);
        set_circ(0, 1, 1, 0);
        start_job(0, 0, 1, 0, 1'b1);  wait_valid(n);

        // Three coincident circles: m is 0 or 3.
        set_circ(0, 4, 4, 2); set_circ(1, 4, 4, 2); set_circ(2, 4, 4, 2);
        start_job(3, 2, 0, 0, 1'b1);  wait_valid(n);
        start_job(6, 0, 13, 0, 1'b1); wait_valid(n);
        start_job(5, 0, 13, 0, 1'b1); wait_valid(n);
        start_job(7, 0, 0, 1, 1'b1);  wait_valid(n);

        // C1 is the single point (5,4) inside C0: m==1 -> 12, m>=2 -> 1, m>=1 -> 13.
        set_circ(1, 5, 4, 0); circ_off(2);
        start_job(3, 1, 12, 0, 1'b1); wait_valid(n);
        start_job(4, 2, 1, 0, 1'b1);  wait_valid(n);
        start_job(4, 1, 13, 0, 1'b1); wait_valid(n);

        // Let the last result drain, then hold a result with out_ready low.
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        set_circ(0, 4, 4, 2); circ_off(1); circ_off(2);
        start_job(0, 0, 13, 0, 1'b1);
        wait_valid(n);
        for (int i = 0; i < 10; i++) begin
            set_circ(0, 8, 8, 15);
            mode = 3'd0;
            en   = 1'b1;
            @(posedge clk);
            #1;
            check("hold_valid", int'(valid), 1);
            check("hold_candidate", int'(candidate), 13);
        end
        // Consume and start the next job on the same edge: (1,1) r=0 -> 1.
        set_circ(0, 1, 1, 0);
        out_ready = 1'b1;
        start_job(0, 0, 1, 0, 1'b1);
        check("restart_busy", int'(busy), 1);
        check("restart_valid", int'(valid), 0);
        check("restart_candidate", int'(candidate), 0);
        wait_valid(n);

        // Reset in the middle of a scan at index 30.
        @(posedge clk);
        #1;
        set_circ(0, 4, 4, 2);
        start_job(0, 0, 13, 0, 1'b0);
        repeat (30) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", int'(busy), 0);
        check("midrst_valid", int'(valid), 0);
        check("midrst_candidate", int'(candidate), 0);
        check("midrst_mode_err", int'(mode_err), 0);
        seen = 0;
        for (int i = 0; i < 80; i++) begin
            @(posedge clk);
            #1;
            if (valid) seen = 1;
        end
        check("no_valid_after_rst", seen, 0);

        // A clean job after the reset.
        start_job(0, 0, 13, 0, 1'b1);
        wait_valid(n);
        check("latency_after_rst", n, 65);

        // LANES=4 instance: same scenario, 17-edge latency.
        @(posedge clk);
        #1;
        begin
            exp_t e;
            e.id = job_id; e.cand = 8'd13; e.err = 1'b0;
            q4.push_back(e);
            job_id++;
        end
        mode = 3'd0;
        en4  = 1'b1;
        @(posedge clk);
        #1;
        en4 = 1'b0;
        n = 0;
        while (!valid4 && n < 300) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("latency_l4", n, 17);

        repeat (4) @(posedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        check("queue_drained_l4", q4.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/set_region_counter.md
Name: set_region_counter

Overview:
- Parametrised successor of the lattice-point set counter.
- Scans a GRID_W x GRID_W integer grid (x,y in 1..GRID_W) and counts the points whose membership in NUM_CIRC circles satisfies a selected set-mode.
- Evaluates LANES points per cycle through a one-stage registered pipeline.
- Result is held with a valid/ready handshake, so back-to-back jobs need no idle cycle.

Parameters:
- GRID_W, 8: points per axis; GRID_W*GRID_W must be divisible by LANES.
- COORD_W, 4: bits per coordinate and per radius.
- NUM_CIRC, 3: number of circles, minimum 2.
- LANES, 1: points evaluated per cycle; power of 2.
- CNT_W, 8: candidate width; must hold GRID_W*GRID_W.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  job start request; configuration is sampled on the same edge.
- central  in  NUM_CIRC*2*COORD_W  circle centres {x,y} per circle; circle 0 in the MSBs.
- radius  in  NUM_CIRC*COORD_W  radii; circle 0 in the MSBs.
- mode  in  3  set-mode select.
- k  in  KW=clog2(NUM_CIRC+1)  membership threshold for modes 3 and 4.
- out_ready  in  1  consumer accepts the result.
- busy  out  1  high in SCAN and DRAIN.
- valid  out  1  candidate is final.
- candidate  out  CNT_W  point count.
- mode_err  out  1  reserved mode used; qualified by valid.

Behaviour:
- Reset is synchronous, on clk, and dominates everything.
  - State goes to IDLE.
  - busy=0, valid=0, mode_err=0, candidate=0, scan index=0, pipeline hit register=0.
  - Reset mid-job abandons the job and produces no valid.
- States: IDLE, SCAN, DRAIN, DONE. S = GRID_W*GRID_W/LANES.
- Job accept:
  - en is accepted in IDLE, or in DONE when out_ready=1 on the same edge.
  - en is ignored in SCAN and DRAIN, and in DONE when out_ready=0.
- On accept:
  - central, radius, mode and k are latched.
  - candidate is cleared to 0, scan index is set to 0, and the state goes to SCAN.
- Point mapping:
  - Lane j at index i evaluates point p = i*LANES + j.
  - x = p / GRID_W + 1, y = p mod GRID_W + 1.
- Membership:
  - Circle c contains a point when dx*dx + dy*dy <= r*r.
  - dx and dy are absolute differences, COORD_W bits each.
  - Squares are exact, 2*COORD_W bits; the sum is 2*COORD_W+1 bits.
  - No saturation is applied; for example 15*15 = 225.
  - Centres may lie outside the grid.
- Modes, where m = number of circles containing the point:
  - 0: C0.
  - 1: C0 & C1.
  - 2: C0 ^ C1.
  - 3: m == k.
  - 4: m >= k.
  - 5: m >= 1.
  - 6: m == NUM_CIRC.
  - 7: reserved; hit is always 0 and mode_err=1 at DONE.
- Pipeline:
  - Per-lane hits are registered on the edge after the evaluation cycle.
  - candidate += popcount(hit register) on the following edge.
- Transitions:
  - SCAN goes to DRAIN on the edge where index = S-1.
  - DRAIN lasts 1 cycle, then goes to DONE.
  - Entering DONE sets valid=1.
- Latency: en accepted at edge E0 gives valid high from edge E0+S+1. The default configuration gives 65 edges.
- DONE:
  - valid, candidate and mode_err hold stable until an edge with out_ready=1.
  - On that edge: with en=1, start a new job (valid drops, candidate clears); with en=0, go to IDLE and drop valid.
  - candidate keeps its last value in IDLE.
- out_ready outside DONE has no effect.

Decomposition:
- Shared package set_pkg:
  - mode constants MODE_C0 .. MODE_RSVD.
  - state encoding.
  - clog2 function.
  - KW derivation.
- Sub-module set_point_judge: one lane.
  - Inputs: point x, point y, latched configuration.
  - Output: combinational hit.
  - Instantiated LANES times through generate.
- Top level holds the FSM, index counter, hit register and accumulator.

Test Plan:
- Circle 0 at (4,4) with r=2, mode 0 -> candidate=13, mode_err=0, valid first high exactly 65 edges after en.
- Circles 0 and 1 both at (4,4) with r=2:
  - mode 1 -> 13.
  - mode 2 -> 0.
- Circle 0 at (8,8) with r=15, mode 0 -> 64; circle 0 at (1,1) with r=0, mode 0 -> 1.
- NUM_CIRC=3, all circles at (4,4) with r=2:
  - mode 3, k=2 -> 0.
  - mode 6 -> 13.
  - mode 5 -> 13.
  - mode 7 -> 0 with mode_err=1.
- Handshake:
  - out_ready=0 for 10 cycles in DONE -> valid and candidate hold and en is ignored.
  - Then out_ready=1 with en=1 -> new job starts, candidate=0, busy=1 on the next cycle.
- Reset and lanes:
  - rst during SCAN at index 30 -> all outputs 0, state IDLE, no valid.
  - With LANES=4, repeat the first scenario -> 13 with valid 17 edges after en.
